adsr_envelope: RTL and testbench

Per-voice ADSR amplitude envelope. Sits directly downstream of the harmonic wavetable synthesizers. It takes the summed or single-harmonic 16-bit wavetable sample and scales it by a 16-bit envelope level. The level advances once per sample_Clk strobe and is driven by a key gate. The output feeds the voice mixer and codec path.

---
 rtl/adsr_envelope.sv | 134 +++++++++++++
 tb/tb_adsr_envelope.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator that scales a signed wavetable sample by a 16-bit level.
// Define ADSR_EXP_RELEASE_EN for an exponential release curve instead of a linear one.
module adsr_envelope #(
  parameter int DATA_W = 16,
  parameter int LVL_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              sample_Clk,
  input  logic              CS,
  input  logic              gate,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [LVL_W-1:0]  attack_rate,
  input  logic [LVL_W-1:0]  decay_rate,
  input  logic [LVL_W-1:0]  sustain_level,
  input  logic [LVL_W-1:0]  release_rate,
  output logic [DATA_W-1:0] sample_out,
  output logic              out_valid,
  output logic [LVL_W-1:0]  env_level,
  output logic [2:0]        state,
  output logic              active
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ATTACK  = 3'd1;
  localparam logic [2:0] DECAY   = 3'd2;
  localparam logic [2:0] SUSTAIN = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  localparam logic [LVL_W-1:0] FULL   = '1;
  localparam int               PROD_W = DATA_W + LVL_W + 1;

  logic [2:0]               state_reg, state_next;
  logic [LVL_W-1:0]         level_reg, level_next;
  logic [DATA_W-1:0]        sample_out_reg;
  logic                     out_valid_reg;
  logic signed [PROD_W-1:0] product;
  logic [LVL_W:0]           attack_sum;
  logic [LVL_W-1:0]         sustain_gap;
  logic [LVL_W:0]           release_dec;
  logic                     unused_bits;

  // Level is treated as a non-negative Q0.16 gain; the >>> LVL_W is a plain bit select.
  assign product = $signed(sample_in) * $signed({1'b0, level_reg});

  assign attack_sum  = {1'b0, level_reg} + {1'b0, attack_rate};
  assign sustain_gap = level_reg - sustain_level;

`ifdef ADSR_EXP_RELEASE_EN
  assign release_dec = {1'b0, level_reg >> release_rate[3:0]} + (LVL_W+1)'(1);
  assign unused_bits = ^{product[LVL_W-1:0], product[PROD_W-1], release_rate[LVL_W-1:4]};
`else
  assign release_dec = (release_rate == '0) ? (LVL_W+1)'(1) : {1'b0, release_rate};
  assign unused_bits = ^{product[LVL_W-1:0], product[PROD_W-1]};
`endif

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    case (state_reg)
      IDLE: begin
        if (gate) begin
          state_next = ATTACK;
          level_next = (attack_sum >= {1'b0, FULL}) ? FULL : attack_sum[LVL_W-1:0];
        end
      end
      ATTACK: begin
        if (!gate) begin
          state_next = RELEASE;
        end else if (attack_sum >= {1'b0, FULL}) begin
          state_next = DECAY;
          level_next = FULL;
        end else begin
          level_next = attack_sum[LVL_W-1:0];
        end
      end
      DECAY: begin
        if (!gate) begin
          state_next = RELEASE;
        end else if ((level_reg <= sustain_level) || (decay_rate >= sustain_gap)) begin
          state_next = SUSTAIN;
          level_next = sustain_level;
        end else begin
          level_next = level_reg - decay_rate;
        end
      end
      SUSTAIN: begin
        if (!gate) begin
          state_next = RELEASE;
        end else begin
          level_next = sustain_level;
        end
      end
      RELEASE: begin
        // Retrigger resumes the attack from wherever the release has got to.
        if (gate) begin
          state_next = ATTACK;
        end else if (release_dec >= {1'b0, level_reg}) begin
          state_next = IDLE;
          level_next = '0;
        end else begin
          level_next = level_reg - release_dec[LVL_W-1:0];
        end
      end
      default: begin
        state_next = IDLE;
        level_next = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || !CS) begin
      state_reg      <= IDLE;
      level_reg      <= '0;
      sample_out_reg <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      out_valid_reg <= sample_Clk;
      if (sample_Clk) begin
        state_reg      <= state_next;
        level_reg      <= level_next;
        sample_out_reg <= product[LVL_W +: DATA_W];
      end
    end
  end

  assign sample_out = sample_out_reg;
  assign out_valid  = out_valid_reg;
  assign env_level  = level_reg;
  assign state      = state_reg;
  assign active     = (state_reg != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed envelope walk-through plus randomized run against an arithmetic model.
module tb_adsr_envelope;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        sample_Clk = 1'b0;
  logic        CS = 1'b0;
  logic        gate = 1'b0;
  logic [15:0] sample_in = '0;
  logic [15:0] attack_rate = '0;
  logic [15:0] decay_rate = '0;
  logic [15:0] sustain_level = '0;
  logic [15:0] release_rate = '0;
  logic [15:0] sample_out;
  logic        out_valid;
  logic [15:0] env_level;
  logic [2:0]  state;
  logic        active;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  // Behavioural model: state numbers are the externally visible encoding.
  int m_state = 0;
  int m_level = 0;
  int m_out = 0;
  int m_valid = 0;

  adsr_envelope dut (
    .Clk(Clk), .Reset(Reset), .sample_Clk(sample_Clk), .CS(CS), .gate(gate),
    .sample_in(sample_in), .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .sample_out(sample_out), .out_valid(out_valid), .env_level(env_level),
    .state(state), .active(active)
  );

  always #5 Clk = ~Clk;

  // Floor-division scaling: sample * level / 65536, rounded toward minus infinity.
  function automatic int scale(input logic [15:0] s, input int lvl);
    longint p;
    longint q;
    p = longint'($signed(s)) * longint'(lvl);
    if (p >= 0) q = p / 65536;
    else q = -((-p + 65535) / 65536);
    return int'(q) & 32'hFFFF;
  endfunction

  always @(posedge Clk) begin
    int st;
    int lvl;
    int dec;
    st = m_state;
    lvl = m_level;
    if (Reset || !CS) begin
      m_state <= 0; m_level <= 0; m_out <= 0; m_valid <= 0;
    end else begin
      m_valid <= sample_Clk ? 1 : 0;
      if (sample_Clk) begin
        m_out <= scale(sample_in, m_level);
        case (m_state)
          0: if (gate) begin st = 1; lvl = (lvl + attack_rate > 65535) ? 65535 : lvl + attack_rate; end
          1: if (!gate) st = 4;
             else if (lvl + attack_rate >= 65535) begin lvl = 65535; st = 2; end
             else lvl = lvl + attack_rate;
          2: if (!gate) st = 4;
             else if (lvl - int'(decay_rate) <= int'(sustain_level)) begin lvl = sustain_level; st = 3; end
             else lvl = lvl - decay_rate;
          3: if (!gate) st = 4; else lvl = sustain_level;
          default: begin
            if (gate) st = 1;
            else begin
`ifdef ADSR_EXP_RELEASE_EN
              dec = (lvl >> release_rate[3:0]) + 1;
`else
              dec = (release_rate == 0) ? 1 : int'(release_rate);
`endif
              lvl = (lvl - dec < 0) ? 0 : lvl - dec;
              if (lvl == 0) st = 0;
            end
          end
        endcase
        m_state <= st;
        m_level <= lvl;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (checking) begin
      cmp("state", int'(state), m_state);
      cmp("env_level", int'(env_level), m_level);
      cmp("active", int'(active), (m_state != 0) ? 1 : 0);
      cmp("out_valid", int'(out_valid), m_valid);
      cmp("sample_out", int'(sample_out), m_out);
      $display("cycle @%0t: state=%0d level=%h out=%h valid=%0d", $time, state, env_level, sample_out, out_valid);
    end
  end

  task automatic strobe_expect(input int exp_state, input int exp_level);
    sample_Clk = 1'b1;
    @(negedge Clk);
    sample_Clk = 1'b0;
    cmp("lit_state", int'(state), exp_state);
    cmp("lit_level", int'(env_level), exp_level);
    repeat (7) @(negedge Clk);
  endtask

  function automatic logic [15:0] pick_rate();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'($urandom_range(1, 16'h0100));
      default: return 16'($urandom_range(16'h0100, 16'h4000));
    endcase
  endfunction

  initial begin
    @(negedge Clk);
    checking = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; CS = 1'b1;
    @(negedge Clk);
    cmp("lit_reset_state", int'(state), 0);
    cmp("lit_reset_level", int'(env_level), 0);
    cmp("lit_reset_active", int'(active), 0);

    // Attack
    attack_rate = 16'h4000; decay_rate = 16'h1000; sustain_level = 16'h8000;
    release_rate = 16'h2000; sample_in = 16'h4000; gate = 1'b1;
    strobe_expect(1, 16'h4000);
    strobe_expect(1, 16'h8000);
    sample_Clk = 1'b1;
    @(negedge Clk);
    sample_Clk = 1'b0;
    cmp("lit_scale_half", int'(sample_out), 16'h2000);
    cmp("lit_valid_pulse", int'(out_valid), 1);
    @(negedge Clk);
    cmp("lit_valid_drop", int'(out_valid), 0);
    repeat (6) @(negedge Clk);
    strobe_expect(2, 16'hFFFF);

    // Decay toward 0x8000; first strobe also scales a full-negative sample at full level
    sample_in = 16'h8000;
    strobe_expect(2, 16'hEFFF);
    cmp("lit_scale_full", int'(sample_out), 16'h8000);
    for (int k = 2; k <= 7; k++) strobe_expect(2, 16'hFFFF - k * 16'h1000);
    strobe_expect(3, 16'h8000);
    sustain_level = 16'h6000;
    strobe_expect(3, 16'h6000);
    sustain_level = 16'h8000;
    strobe_expect(3, 16'h8000);

    // Release, retrigger, release to idle
    gate = 1'b0;
    strobe_expect(4, 16'h8000);
    strobe_expect(4, 16'h6000);
    strobe_expect(4, 16'h4000);
    gate = 1'b1; attack_rate = 16'h1000;
    strobe_expect(1, 16'h4000);
    strobe_expect(1, 16'h5000);
    gate = 1'b0;
    strobe_expect(4, 16'h5000);
    strobe_expect(4, 16'h3000);
    strobe_expect(4, 16'h1000);
    strobe_expect(0, 16'h0000);
    cmp("lit_idle_active", int'(active), 0);

    // Gate pulse between strobes is invisible
    gate = 1'b1;
    repeat (3) @(negedge Clk);
    gate = 1'b0;
    strobe_expect(0, 16'h0000);

    // Reset and CS abort mid-attack
    gate = 1'b1;
    strobe_expect(1, 16'h1000);
    strobe_expect(1, 16'h2000);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    cmp("lit_abort_reset_state", int'(state), 0);
    cmp("lit_abort_reset_level", int'(env_level), 0);
    cmp("lit_abort_reset_out", int'(sample_out), 0);
    strobe_expect(1, 16'h1000);
    strobe_expect(1, 16'h2000);
    CS = 1'b0;
    @(negedge Clk);
    CS = 1'b1;
    cmp("lit_abort_cs_state", int'(state), 0);
    cmp("lit_abort_cs_level", int'(env_level), 0);
    cmp("lit_abort_cs_out", int'(sample_out), 0);

    // Saturating attack, then sustain at full scale
    attack_rate = 16'hFFFF; sustain_level = 16'hFFFF;
    strobe_expect(1, 16'hFFFF);
    strobe_expect(2, 16'hFFFF);
    strobe_expect(3, 16'hFFFF);

    // Release tail from 0x8000
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    attack_rate = 16'h8000;
    strobe_expect(1, 16'h8000);
    gate = 1'b0;
    strobe_expect(4, 16'h8000);
`ifdef ADSR_EXP_RELEASE_EN
    release_rate = 16'hFFF1;
    strobe_expect(4, 16'h3FFF);
    strobe_expect(4, 16'h1FFF);
    strobe_expect(4, 16'h0FFF);
    gate = 1'b1;
    repeat (2) @(negedge Clk);
    gate = 1'b0;
    strobe_expect(4, 16'h07FF);
    for (int k = 0; k < 20 && state != 3'd0; k++) begin
      sample_Clk = 1'b1;
      @(negedge Clk);
      sample_Clk = 1'b0;
    end
    cmp("lit_exp_idle", int'(state), 0);
`else
    release_rate = 16'h0000;
    strobe_expect(4, 16'h7FFF);
    strobe_expect(4, 16'h7FFE);
    release_rate = 16'hFFFF;
    strobe_expect(0, 16'h0000);
`endif

    // Randomized run: model comparison happens every cycle in the compare process
    for (int c = 0; c < 6000; c++) begin
      sample_Clk = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) gate = ~gate;
      if ($urandom_range(0, 63) == 0) begin
        attack_rate = pick_rate();
        decay_rate = pick_rate();
        release_rate = pick_rate();
        sustain_level = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      end
      sample_in = 16'($urandom);
      CS = ($urandom_range(0, 499) != 0);
      Reset = ($urandom_range(0, 999) == 0);
      @(negedge Clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
